// File: rtl/program_loader_pkg.sv
// rtl/program_loader_pkg.sv - shared state encoding and widths for the program loader
package program_loader_pkg;

   localparam int ADDR_W_DEFAULT = 8;
   localparam int INSTR_W        = 16;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_HDR   = 3'd1,
      S_HI    = 3'd2,
      S_LO    = 3'd3,
      S_WRITE = 3'd4,
      S_DONE  = 3'd5
   } state_t;

endpackage

// File: rtl/program_loader.sv
// rtl/program_loader.sv - byte-stream image loader into instruction memory, holds the CPU until complete
module program_loader
   import program_loader_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEFAULT
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               abort,
   input  logic [7:0]         byte_in,
   input  logic               byte_valid,
   output logic               byte_ready,
   output logic               mem_we,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic [INSTR_W-1:0] mem_data,
   output logic               cpu_hold,
   output logic               load_done
);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   n_q, n_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic [7:0]          hi_q, hi_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [INSTR_W-1:0]  data_q, data_d;
   logic                xfer;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         n_q     <= '0;
         cnt_q   <= '0;
         hi_q    <= '0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   assign byte_ready = ((state_q == S_HDR) || (state_q == S_HI) || (state_q == S_LO)) && !abort;
   assign xfer       = byte_valid && byte_ready;

   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      addr_d  = addr_q;
      data_d  = data_q;
      case (state_q)
         S_IDLE: if (start && !abort) state_d = S_HDR;
         S_HDR: begin
            if (abort) state_d = S_IDLE;
            else if (xfer) begin
               n_d     = ADDR_W'(byte_in);
               cnt_d   = '0;
               state_d = S_HI;
            end
         end
         S_HI: begin
            if (abort) state_d = S_IDLE;
            else if (xfer) begin
               hi_d    = byte_in;
               state_d = S_LO;
            end
         end
         S_LO: begin
            // Address/data are latched here so they are stable for the whole WRITE cycle
            if (abort) state_d = S_IDLE;
            else if (xfer) begin
               data_d  = {hi_q, byte_in};
               addr_d  = cnt_q;
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            if (abort) state_d = S_IDLE;
            else if (cnt_q == n_q) state_d = S_DONE;
            else begin
               cnt_d   = cnt_q + ADDR_W'(1);
               state_d = S_HI;
            end
         end
         S_DONE: if (start && !abort) state_d = S_HDR;
         default: state_d = S_IDLE;
      endcase
   end

   assign mem_we    = (state_q == S_WRITE) && !abort;
   assign mem_addr  = addr_q;
   assign mem_data  = data_q;
   assign cpu_hold  = (state_q != S_DONE);
   assign load_done = (state_q == S_DONE);

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed self-checking bench for program_loader
module tb_program_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        abort;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        byte_ready;
   logic        mem_we;
   logic [7:0]  mem_addr;
   logic [15:0] mem_data;
   logic        cpu_hold;
   logic        load_done;

   int n_assert = 0;
   int n_fail   = 0;

   logic [7:0]  wr_addr [0:1023];
   logic [15:0] wr_data [0:1023];
   int          wr_n = 0;

   program_loader dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .abort      (abort),
      .byte_in    (byte_in),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_data   (mem_data),
      .cpu_hold   (cpu_hold),
      .load_done  (load_done)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (mem_we && wr_n < 1024) begin
         wr_addr[wr_n] = mem_addr;
         wr_data[wr_n] = mem_data;
         wr_n = wr_n + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      bit ok = 0;
      byte_in    = b;
      byte_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (byte_ready) begin
            ok = 1;
            step();
            break;
         end
      end
      byte_valid = 1'b0;
      if (!ok) chk("send_byte_timeout", 32'd0, 32'd1);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      bit ok = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (load_done) begin
            ok = 1;
            break;
         end
      end
      chk(tag, {31'd0, ok}, 32'd1);
      step();
   endtask

   initial begin
      int base;
      int bad;
      logic [15:0] words [0:2];
      reset = 1'b1; start = 1'b0; abort = 1'b0; byte_in = 8'h00; byte_valid = 1'b0;
      words[0] = 16'hAAAA; words[1] = 16'hBBBB; words[2] = 16'hCCCC;

      // Reset state
      @(negedge clk);
      chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
      chk("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
      chk("rst_mem_data", {16'd0, mem_data}, 32'd0);
      chk("rst_load_done", {31'd0, load_done}, 32'd0);
      chk("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
      chk("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
      step();
      reset = 1'b0;
      step();

      // Single-word image, write one cycle after the low byte
      base = wr_n;
      pulse_start();
      send_byte(8'h00);
      send_byte(8'h12);
      send_byte(8'h34);
      @(negedge clk);
      chk("t1_we_latency", {31'd0, mem_we}, 32'd1);
      chk("t1_addr", {24'd0, mem_addr}, 32'd0);
      chk("t1_data", {16'd0, mem_data}, 32'h1234);
      chk("t1_hold_in_write", {31'd0, cpu_hold}, 32'd1);
      step();
      @(negedge clk);
      chk("t1_done", {31'd0, load_done}, 32'd1);
      chk("t1_cpu_hold", {31'd0, cpu_hold}, 32'd0);
      chk("t1_we_low", {31'd0, mem_we}, 32'd0);
      chk("t1_data_held", {16'd0, mem_data}, 32'h1234);
      chk("t1_wr_count", wr_n - base, 32'd1);
      step();

      // Restart from DONE, three words with stalls
      pulse_start();
      @(negedge clk);
      chk("t2_hold_after_start", {31'd0, cpu_hold}, 32'd1);
      chk("t2_done_cleared", {31'd0, load_done}, 32'd0);
      chk("t2_ready_hdr", {31'd0, byte_ready}, 32'd1);
      step();
      base = wr_n;
      send_byte(8'h02);
      for (int w = 0; w < 3; w++) begin
         send_byte(words[w][15:8]);
         repeat (3) step();
         @(negedge clk);
         chk("t2_stall_ready", {31'd0, byte_ready}, 32'd1);
         chk("t2_stall_we", {31'd0, mem_we}, 32'd0);
         chk("t2_stall_done", {31'd0, load_done}, 32'd0);
         step();
         send_byte(words[w][7:0]);
      end
      wait_done("t2_done_timeout");
      chk("t2_wr_count", wr_n - base, 32'd3);
      for (int w = 0; w < 3; w++) begin
         chk("t2_wr_addr", {24'd0, wr_addr[base + w]}, w);
         chk("t2_wr_data", {16'd0, wr_data[base + w]}, {16'd0, words[w]});
      end

      // Full memory: header FF, 256 ascending words
      pulse_start();
      base = wr_n;
      send_byte(8'hFF);
      for (int w = 0; w < 256; w++) begin
         send_byte(8'h10 + 8'(w >> 8));
         send_byte(8'(w));
      end
      wait_done("t3_done_timeout");
      chk("t3_wr_count", wr_n - base, 32'd256);
      chk("t3_last_addr", {24'd0, wr_addr[base + 255]}, 32'hFF);
      chk("t3_last_data", {16'd0, wr_data[base + 255]}, 32'h10FF);
      bad = 0;
      for (int w = 0; w < 256; w++)
         if (wr_addr[base + w] !== 8'(w) || wr_data[base + w] !== (16'h1000 + 16'(w))) bad++;
      chk("t3_seq_errors", bad, 32'd0);

      // Abort with the low byte of word 1 valid
      pulse_start();
      base = wr_n;
      send_byte(8'h01);
      send_byte(8'h55);
      send_byte(8'h55);
      step();
      send_byte(8'h66);
      byte_in = 8'h77; byte_valid = 1'b1; abort = 1'b1;
      @(negedge clk);
      chk("t4_ready_abort", {31'd0, byte_ready}, 32'd0);
      step();
      abort = 1'b0; byte_valid = 1'b0;
      repeat (2) step();
      @(negedge clk);
      chk("t4_idle_ready", {31'd0, byte_ready}, 32'd0);
      chk("t4_cpu_hold", {31'd0, cpu_hold}, 32'd1);
      chk("t4_load_done", {31'd0, load_done}, 32'd0);
      chk("t4_wr_count", wr_n - base, 32'd1);
      chk("t4_wr0_addr", {24'd0, wr_addr[base]}, 32'd0);
      step();
      start = 1'b1; abort = 1'b1;
      step();
      start = 1'b0; abort = 1'b0;
      @(negedge clk);
      chk("t4_start_abort_ignored", {31'd0, byte_ready}, 32'd1 - 32'd1);
      step();

      // Reset while in LO
      pulse_start();
      base = wr_n;
      send_byte(8'h03);
      send_byte(8'h12);
      #2 reset = 1'b1;
      #1;
      chk("t5_rst_we", {31'd0, mem_we}, 32'd0);
      chk("t5_rst_addr", {24'd0, mem_addr}, 32'd0);
      chk("t5_rst_data", {16'd0, mem_data}, 32'd0);
      chk("t5_rst_hold", {31'd0, cpu_hold}, 32'd1);
      chk("t5_rst_done", {31'd0, load_done}, 32'd0);
      chk("t5_rst_ready", {31'd0, byte_ready}, 32'd0);
      step();
      reset = 1'b0;
      step();
      chk("t5_no_write", wr_n - base, 32'd0);
      pulse_start();
      send_byte(8'h00);
      send_byte(8'hBE);
      send_byte(8'hEF);
      wait_done("t5_done_timeout");
      chk("t5_wr_count", wr_n - base, 32'd1);
      chk("t5_wr_data", {16'd0, wr_data[base]}, 32'hBEEF);

      // start pulsed in HI is ignored
      pulse_start();
      base = wr_n;
      send_byte(8'h01);
      pulse_start();
      @(negedge clk);
      chk("t6_still_ready", {31'd0, byte_ready}, 32'd1);
      step();
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33);
      send_byte(8'h44);
      wait_done("t6_done_timeout");
      chk("t6_wr_count", wr_n - base, 32'd2);
      chk("t6_wr0", {wr_addr[base], wr_data[base]}, 32'h00_1122);
      chk("t6_wr1", {wr_addr[base + 1], wr_data[base + 1]}, 32'h01_3344);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter ADDR_W, default 8, instruction-memory word address width; addresses 0 .. 2^ADDR_W-1.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  one-cycle pulse requesting a new load.
REQ-005 abort  input  1  level; cancels an in-progress load.
REQ-006 byte_in  input  8  incoming stream byte.
REQ-007 byte_valid  input  1  byte_in holds a valid byte.
REQ-008 byte_ready  output  1  loader can accept a byte this cycle.
REQ-009 mem_we  output  1  instruction-memory write strobe.
REQ-010 mem_addr  output  ADDR_W  instruction-memory write address.
REQ-011 mem_data  output  16  instruction-memory write data.
REQ-012 cpu_hold  output  1  holds the fetch unit/CPU in reset while high.
REQ-013 load_done  output  1  high while a complete image is resident.

Function
REQ-014 A byte transfer SHALL occur only in a cycle where byte_valid and byte_ready are both high.
REQ-015 Stream format SHALL be: one header byte N (word count minus 1), then N+1 words, each sent high byte first, then low byte.
REQ-016 The FSM SHALL have the states IDLE, HDR, HI, LO, WRITE and DONE.
REQ-017 IDLE: byte_ready low; start moves the FSM to HDR.
REQ-018 HDR: on transfer, capture N, clear the address counter and move to HI.
REQ-019 HI: on transfer, capture the high byte and move to LO.
REQ-020 LO: on transfer, capture the low byte and move to WRITE.
REQ-021 WRITE SHALL last exactly one cycle, with mem_we=1, mem_addr=counter and mem_data={hi,lo}.
REQ-022 WRITE exit: if counter==N, go to DONE; else increment the counter and go to HI.
REQ-023 The mem_we pulse SHALL begin in the cycle after the low-byte transfer (latency 1).
REQ-024 DONE: cpu_hold=0 and load_done=1; start moves the FSM to HDR, and cpu_hold/load_done take their HDR values in the following cycle.
REQ-025 byte_ready SHALL equal (state is HDR, HI or LO) AND NOT abort (combinational).
REQ-026 mem_we SHALL be low in every state except WRITE.
REQ-027 mem_addr and mem_data SHALL be registered and hold their last values outside WRITE.
REQ-028 cpu_hold SHALL be 1 in every state except DONE.
REQ-029 abort in HDR, HI, LO or WRITE SHALL return the FSM to IDLE with no write that cycle; words already written stay, and load_done remains 0.
REQ-030 abort together with byte_valid: abort wins and the byte is not consumed.
REQ-031 abort in IDLE or DONE SHALL have no effect.
REQ-032 start outside IDLE and DONE SHALL be ignored.
REQ-033 start together with abort: abort wins, and start is ignored in IDLE and DONE.
REQ-034 N=2^ADDR_W-1 SHALL load the full memory with the counter ending at its maximum; the address SHALL never wrap within one load.
REQ-035 byte_valid low in HDR, HI or LO SHALL stall the FSM indefinitely with all outputs held.

Reset
REQ-036 Reset SHALL force the FSM to IDLE asynchronously.
REQ-037 Reset values: mem_we=0, mem_addr=0, mem_data=0, load_done=0, cpu_hold=1, byte_ready=0.
REQ-038 Reset asserted mid-load SHALL suppress any pending write immediately.

Structure
REQ-039 The shared package SHALL hold the state encoding, ADDR_W default and the 16-bit instruction width constant.
REQ-040 Single module, no sub-modules: FSM, address counter, N register and byte registers.

Verification
REQ-041 Reset, start, then bytes 00,12,34 -> one mem_we at addr 0 with data 1234 one cycle after byte 34; DONE; cpu_hold=0.
REQ-042 Header 02, then words AAAA,BBBB,CCCC with byte_valid gaps -> writes at addr 0,1,2, stalls hold outputs, load_done after the third write.
REQ-043 Header FF, 256 ascending words -> last write at addr FF with no wrap to 00; DONE.
REQ-044 abort asserted with the low byte of word 1 valid -> byte not consumed, no write at addr 1, IDLE, cpu_hold=1, load_done=0.
REQ-045 Reset pulsed while in LO -> all outputs return to reset values immediately with no mem_we; a subsequent start loads normally.
REQ-046 start pulsed in HI -> ignored; start from DONE -> cpu_hold=1 next cycle and a new header is accepted.
